// File: rtl/mem_wait_responder_if.sv
// Single-port memory bus between the multi-cycle core (master) and its memory (slave):
// req/we/addr/wd forward, rd/ready/err back.
interface mem_wait_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;

  modport master (
    output req, we, addr, wd,
    input  rd, ready, err
  );

  modport slave (
    input  req, we, addr, wd,
    output rd, ready, err
  );
endinterface

// File: rtl/mem_wait_responder.sv
// Unified word memory with programmable wait states and error flagging for misaligned or
// out-of-range accesses. Define MEM_WAIT_STATS_EN to add read/write/error access counters.
module mem_wait_responder #(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_wait_responder_if.slave  bus
`ifdef MEM_WAIT_STATS_EN
  ,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic [15:0]          err_count
`endif
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, wd_q, rd_q;
  logic          we_q;
  logic          latch_en;

  logic [31:0]   mem_q [DEPTH];

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  // With LATENCY=1 the RESP entry edge is also the latch edge, so the commit must use the live bus.
  logic          acc_we;
  logic [31:0]   acc_addr, acc_wd;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          enter_resp;
  logic          mem_we;
  logic [31:0]   rd_d;

  always_comb begin
    acc_we   = (state_q == IDLE) ? bus.we   : we_q;
    acc_addr = (state_q == IDLE) ? bus.addr : addr_q;
    acc_wd   = (state_q == IDLE) ? bus.wd   : wd_q;
    acc_err  = addr_err(acc_addr);
    acc_idx  = acc_addr[AW+1:2];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          latch_en = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An access interrupted by reset must never reach the array.
  assign enter_resp = (state_d == RESP) && (state_q != RESP) && !reset;
  assign mem_we     = enter_resp && acc_we && !acc_err;

  always_comb begin
    rd_d = rd_q;
    if (enter_resp) begin
      if (acc_err)     rd_d = '0;
      else if (acc_we) rd_d = acc_wd;
      else             rd_d = mem_q[acc_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      if (latch_en) begin
        addr_q <= bus.addr;
        wd_q   <= bus.wd;
        we_q   <= bus.we;
      end
    end
  end

  // NOTE: the array is deliberately left out of reset; its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[acc_idx] <= acc_wd;
  end

  assign bus.ready = (state_q == RESP);
  assign bus.err   = (state_q == RESP) && addr_err(addr_q);
  assign bus.rd    = rd_q;

`ifdef MEM_WAIT_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;
  logic [15:0] err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else if (state_q == RESP) begin
      if (addr_err(addr_q)) err_count_q <= err_count_q + 16'd1;
      else if (we_q)        wr_count_q  <= wr_count_q + 32'd1;
      else                  rd_count_q  <= rd_count_q + 32'd1;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: one LATENCY=2 and one LATENCY=1 instance,
// expected responses queued at request time and compared when ready is seen.
module tb_mem_wait_responder;

  logic clk;
  logic reset;

  mem_wait_responder_if b2 ();
  mem_wait_responder_if b1 ();

`ifdef MEM_WAIT_STATS_EN
  logic [31:0] rdc2, wrc2, rdc1, wrc1;
  logic [15:0] erc2, erc1;
`endif

  mem_wait_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
`ifdef MEM_WAIT_STATS_EN
    ,
    .rd_count  (rdc2),
    .wr_count  (wrc2),
    .err_count (erc2)
`endif
  );

  mem_wait_responder #(.DEPTH(64), .LATENCY(1)) u_lat1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
`ifdef MEM_WAIT_STATS_EN
    ,
    .rd_count  (rdc1),
    .wr_count  (wrc1),
    .err_count (erc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 2) begin
      b2.req = req; b2.we = we; b2.addr = addr; b2.wd = wd;
    end else begin
      b1.req = req; b1.we = we; b1.addr = addr; b1.wd = wd;
    end
  endtask

  task automatic sample(input int sel, output logic rdy, output logic e, output logic [31:0] r);
    if (sel == 2) begin
      rdy = b2.ready; e = b2.err; r = b2.rd;
    end else begin
      rdy = b1.ready; e = b1.err; r = b1.rd;
    end
  endtask

  // Drive a request at the current negedge and queue its expected response.
  task automatic start(input int sel, input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat);
    sb_item_t it;
    it.tag = tag; it.rd = exp_rd; it.err = exp_err; it.lat = exp_lat;
    sb.push_back(it);
    drive(sel, 1'b1, we, addr, wd);
  endtask

  // Wait (bounded) for ready, then compare latency, rd and err with the queued entry.
  task automatic wait_resp(input int sel);
    sb_item_t    exp;
    int          n;
    logic        rdy, e;
    logic [31:0] r;
    exp = sb.pop_front();
    n   = 0;
    rdy = 1'b0;
    e   = 1'b0;
    r   = '0;
    while (!rdy && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      sample(sel, rdy, e, r);
    end
    check({exp.tag, "/lat"}, n, exp.lat);
    check({exp.tag, "/rd"},  r, exp.rd);
    check({exp.tag, "/err"}, {31'd0, e}, {31'd0, exp.err});
  endtask

  // Release req and confirm ready was a single-cycle strobe.
  task automatic end_access(input int sel, input string tag);
    logic        rdy, e;
    logic [31:0] r;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    sample(sel, rdy, e, r);
    check({tag, "/ready_low"}, {31'd0, rdy}, 32'd0);
    check({tag, "/err_low"},   {31'd0, e},   32'd0);
  endtask

  task automatic access(input int sel, input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    start(sel, tag, we, addr, wd, exp_rd, exp_err, (sel == 2) ? 2 : 1);
    wait_resp(sel);
    end_access(sel, tag);
  endtask

  initial begin
    logic        rdy, e;
    logic [31:0] r;

    reset = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset: nothing may respond.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      sample(2, rdy, e, r);
      check("idle2/ready", {31'd0, rdy}, 32'd0);
      check("idle2/err",   {31'd0, e},   32'd0);
      check("idle2/rd",    r,            32'd0);
      sample(1, rdy, e, r);
      check("idle1/ready", {31'd0, rdy}, 32'd0);
      check("idle1/rd",    r,            32'd0);
    end

    // LATENCY=2: write, read-back, misaligned and out-of-range errors.
    access(2, "wr10",   1'b1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    access(2, "rd10",   1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    access(2, "wr12",   1'b1, 32'h12,  32'h11111111, 32'h0,        1'b1);
    access(2, "wr100",  1'b1, 32'h100, 32'h22222222, 32'h0,        1'b1);
    access(2, "rd10b",  1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    access(2, "wr20",   1'b1, 32'h20,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    access(2, "rd20",   1'b0, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0);

`ifdef MEM_WAIT_STATS_EN
    check("stats2/rd",  rdc2,          32'd3);
    check("stats2/wr",  wrc2,          32'd2);
    check("stats2/err", {16'd0, erc2}, 32'd2);
`endif

    // LATENCY=1: preload two words, then back-to-back reads with req held high.
    access(1, "wr0", 1'b1, 32'h0, 32'h20080005, 32'h20080005, 1'b0);
    access(1, "wr4", 1'b1, 32'h4, 32'h2003000C, 32'h2003000C, 1'b0);
    start(1, "b2b0", 1'b0, 32'h0, 32'h0, 32'h20080005, 1'b0, 1);
    wait_resp(1);
    start(1, "b2b4", 1'b0, 32'h4, 32'h0, 32'h2003000C, 1'b0, 2);
    wait_resp(1);
    end_access(1, "b2b4");

`ifdef MEM_WAIT_STATS_EN
    check("stats1/rd",  rdc1,          32'd2);
    check("stats1/wr",  wrc1,          32'd2);
    check("stats1/err", {16'd0, erc1}, 32'd0);
`endif

    // Reset during WAIT of a write: dropped, no ready, old contents survive.
    drive(2, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    sample(2, rdy, e, r);
    check("abort/wait_ready", {31'd0, rdy}, 32'd0);
    reset = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(2, rdy, e, r);
      check("abort/ready", {31'd0, rdy}, 32'd0);
      check("abort/rd",    r,            32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    access(2, "rd20_after", 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef MEM_WAIT_STATS_EN
    check("stats2r/rd",  rdc2,          32'd1);
    check("stats2r/wr",  wrc2,          32'd0);
    check("stats2r/err", {16'd0, erc2}, 32'd0);
`endif

    check("sb/empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
